// File: rtl/heat_zone_controller.sv
// heat_zone_controller
//
// Multi-zone heating controller. It holds one registered operating mode
// (OFF, COMFORT, ECO, FROST). For each zone it runs a hysteresis thermostat
// with minimum-on and minimum-off dwell timers, and it drives one heater
// valve per zone plus a boiler request.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   mode_sel     requested mode: 0=OFF, 1=COMFORT, 2=ECO, 3=FROST
//   mode_load    capture mode_sel into active_mode
//   zone_en      per-zone enable; a disabled zone behaves as mode OFF
//   zone_temp    packed zone temperatures, zone i at [i*TEMP_W +: TEMP_W]
//   active_mode  registered current mode
//   mode_changed one-cycle pulse when active_mode takes a different value
//   heater_on    registered per-zone heater command
//   boiler_req   OR of heater_on
module heat_zone_controller #(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned TEMP_W      = 8,
    parameter int unsigned HYST        = 2,
    parameter int unsigned SP_COMFORT  = 44,
    parameter int unsigned SP_ECO      = 36,
    parameter int unsigned SP_FROST    = 14,
    parameter int unsigned MIN_ON_CYC  = 16,
    parameter int unsigned MIN_OFF_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode_sel,
    input  logic                        mode_load,
    input  logic [NUM_ZONES-1:0]        zone_en,
    input  logic [NUM_ZONES*TEMP_W-1:0] zone_temp,
    output logic [1:0]                  active_mode,
    output logic                        mode_changed,
    output logic [NUM_ZONES-1:0]        heater_on,
    output logic                        boiler_req
);

    localparam int unsigned MAX_CYC = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
    // A one-cycle dwell still needs a 1-bit counter that holds 0.
    localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF_CYC - 1);
    localparam longint unsigned T_MAX = (64'd1 << TEMP_W) - 64'd1;

    // Lower threshold, saturating at zero.
    function automatic logic [TEMP_W-1:0] lo_of(input int unsigned sp);
        if (sp > HYST) begin
            return TEMP_W'(sp - HYST);
        end
        return '0;
    endfunction

    // Upper threshold, saturating at the top of the temperature range.
    function automatic logic [TEMP_W-1:0] hi_of(input int unsigned sp);
        longint unsigned s;
        s = 64'(sp) + 64'(HYST);
        if (s > T_MAX) begin
            return TEMP_W'(T_MAX);
        end
        return TEMP_W'(s);
    endfunction

    localparam logic [TEMP_W-1:0] LO_COMFORT = lo_of(SP_COMFORT);
    localparam logic [TEMP_W-1:0] HI_COMFORT = hi_of(SP_COMFORT);
    localparam logic [TEMP_W-1:0] LO_ECO     = lo_of(SP_ECO);
    localparam logic [TEMP_W-1:0] HI_ECO     = hi_of(SP_ECO);
    localparam logic [TEMP_W-1:0] LO_FROST   = lo_of(SP_FROST);
    localparam logic [TEMP_W-1:0] HI_FROST   = hi_of(SP_FROST);

    typedef enum logic [1:0] {
        StOffReady,
        StOnHold,
        StOnReady,
        StOffHold
    } zone_state_e;

    logic [TEMP_W-1:0] lo_thr;
    logic [TEMP_W-1:0] hi_thr;

    // Mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_mode  <= 2'd0;
            mode_changed <= 1'b0;
        end else if (mode_load) begin
            active_mode  <= mode_sel;
            mode_changed <= (mode_sel != active_mode);
        end else begin
            mode_changed <= 1'b0;
        end
    end

    // OFF has no setpoint; every zone is forced off then, so the values are don't-care.
    always_comb begin
        lo_thr = '0;
        hi_thr = '1;
        case (active_mode)
            2'd1: begin
                lo_thr = LO_COMFORT;
                hi_thr = HI_COMFORT;
            end
            2'd2: begin
                lo_thr = LO_ECO;
                hi_thr = HI_ECO;
            end
            2'd3: begin
                lo_thr = LO_FROST;
                hi_thr = HI_FROST;
            end
            default: begin
                lo_thr = '0;
                hi_thr = '1;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
        zone_state_e       state;
        logic [CNT_W-1:0]  timer;
        logic              heat;
        logic [TEMP_W-1:0] temp;
        logic              forced;

        assign temp         = zone_temp[i*TEMP_W +: TEMP_W];
        assign forced       = (active_mode == 2'd0) || !zone_en[i];
        assign heater_on[i] = heat;

        // On the edge where a hold timer expires the ready-state decision is
        // taken as well, so each dwell lasts exactly MIN_*_CYC cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= StOffReady;
                timer <= '0;
                heat  <= 1'b0;
            end else begin
                case (state)
                    StOffReady: begin
                        if (!forced && (temp < lo_thr)) begin
                            state <= StOnHold;
                            heat  <= 1'b1;
                            timer <= ON_LOAD;
                        end
                    end
                    StOnHold: begin
                        if (forced) begin
                            // Safety: forced off overrides the min-on dwell.
                            state <= StOffHold;
                            heat  <= 1'b0;
                            timer <= OFF_LOAD;
                        end else if (timer == '0) begin
                            if (temp >= hi_thr) begin
                                state <= StOffHold;
                                heat  <= 1'b0;
                                timer <= OFF_LOAD;
                            end else begin
                                state <= StOnReady;
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    StOnReady: begin
                        if (forced || (temp >= hi_thr)) begin
                            state <= StOffHold;
                            heat  <= 1'b0;
                            timer <= OFF_LOAD;
                        end
                    end
                    StOffHold: begin
                        // Min-off is never overridden.
                        if (timer == '0) begin
                            if (!forced && (temp < lo_thr)) begin
                                state <= StOnHold;
                                heat  <= 1'b1;
                                timer <= ON_LOAD;
                            end else begin
                                state <= StOffReady;
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: begin
                        state <= StOffReady;
                        heat  <= 1'b0;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    assign boiler_req = |heater_on;

endmodule
